// File: rtl/l1_cache_pkg.sv
// Shared L1 data-cache parameters, address field positions and the
// L1<->L2 line bridge state encoding.
package l1_cache_pkg;

    localparam int ADDR_W      = 32;
    localparam int LINE_W      = 512;
    localparam int BEAT_W      = 64;
    localparam int BEATS       = LINE_W / BEAT_W;
    localparam int BEAT_IDX_W  = $clog2(BEATS);
    localparam int BYTE_OFF_W  = $clog2(BEAT_W / 8);
    localparam int OFFSET_W    = $clog2(LINE_W / 8);
    localparam int LINE_ADDR_W = ADDR_W - OFFSET_W;

    localparam int OFFSET_LO = 0;
    localparam int OFFSET_HI = OFFSET_W - 1;
    localparam int INDEX_LO  = 6;
    localparam int INDEX_HI  = 11;
    localparam int TAG_LO    = 12;
    localparam int TAG_HI    = ADDR_W - 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_BEAT,
        WR_DONE,
        RD_BEAT,
        RD_DONE
    } bridge_state_t;

    // Byte address of one beat within a line: line-aligned plus beat*8.
    function automatic logic [ADDR_W-1:0] beat_addr(
        input logic [LINE_ADDR_W-1:0] line,
        input logic [BEAT_IDX_W-1:0]  beat
    );
        return {line, beat, {BYTE_OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/line_beat_shifter.sv
// Line storage for the bridge: a victim line register that is read out one
// beat at a time and a refill line register that is filled one beat at a time.
module line_beat_shifter
    import l1_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [LINE_W-1:0]     load_line,
    input  logic [BEAT_IDX_W-1:0] beat,
    input  logic                  merge,
    input  logic [BEAT_W-1:0]     merge_data,
    output logic [BEAT_W-1:0]     wr_beat,
    output logic [LINE_W-1:0]     rd_line
);

    logic [BEAT_W-1:0] wr_slots [BEATS];

    // The refill copy is separate so a writeback never disturbs the line
    // last handed to L1.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [BEAT_W-1:0] wr_slot_reg;
            logic [BEAT_W-1:0] rd_slot_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_slot_reg <= '0;
                    rd_slot_reg <= '0;
                end else begin
                    if (load) begin
                        wr_slot_reg <= load_line[gi*BEAT_W +: BEAT_W];
                    end
                    if (merge && beat == BEAT_IDX_W'(gi)) begin
                        rd_slot_reg <= merge_data;
                    end
                end
            end

            assign wr_slots[gi]                  = wr_slot_reg;
            assign rd_line[gi*BEAT_W +: BEAT_W] = rd_slot_reg;
        end
    endgenerate

    assign wr_beat = wr_slots[beat];

endmodule

// File: rtl/l1_d_l2_bridge.sv
// Moves whole 512-bit cache lines between the L1 data-cache controller and
// the L2 port as eight 64-bit beats; writeback has priority over refill.
module l1_d_l2_bridge
    import l1_cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              read_L1_L2,
    input  logic              write_L1_L2,
    input  logic [ADDR_W-1:0] addr_L1_L2,
    input  logic [LINE_W-1:0] wdata_L1_L2,
    output logic              ready_L2_L1,
    output logic              write_L1_L2_done,
    output logic [LINE_W-1:0] rdata_L2_L1,
    output logic              busy,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [BEAT_W-1:0] l2_wdata,
    input  logic              l2_ack,
    input  logic [BEAT_W-1:0] l2_rdata
);

    bridge_state_t          state_reg;
    logic [BEAT_IDX_W-1:0]  beat_reg;
    logic [LINE_ADDR_W-1:0] line_addr_reg;
    logic                   load_victim;
    logic                   merge_beat;
    logic                   unused_offset;

    assign unused_offset = ^addr_L1_L2[OFFSET_HI:OFFSET_LO];

    assign load_victim = (state_reg == IDLE) && write_L1_L2;
    assign merge_beat  = (state_reg == RD_BEAT) && l2_ack;
    assign l2_addr     = beat_addr(line_addr_reg, beat_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            beat_reg         <= '0;
            line_addr_reg    <= '0;
            l2_req           <= 1'b0;
            l2_we            <= 1'b0;
            busy             <= 1'b0;
            ready_L2_L1      <= 1'b0;
            write_L1_L2_done <= 1'b0;
        end else begin
            ready_L2_L1      <= 1'b0;
            write_L1_L2_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (write_L1_L2 || read_L1_L2) begin
                        state_reg     <= write_L1_L2 ? WR_BEAT : RD_BEAT;
                        line_addr_reg <= addr_L1_L2[ADDR_W-1:OFFSET_W];
                        beat_reg      <= '0;
                        l2_req        <= 1'b1;
                        l2_we         <= write_L1_L2;
                        busy          <= 1'b1;
                    end
                end
                WR_BEAT, RD_BEAT: begin
                    // Counter wraps to zero on the last beat so l2_addr
                    // falls back to the line base on exit.
                    if (l2_ack) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == BEAT_IDX_W'(BEATS - 1)) begin
                            l2_req <= 1'b0;
                            l2_we  <= 1'b0;
                            if (state_reg == WR_BEAT) begin
                                state_reg        <= WR_DONE;
                                write_L1_L2_done <= 1'b1;
                            end else begin
                                state_reg   <= RD_DONE;
                                ready_L2_L1 <= 1'b1;
                            end
                        end
                    end
                end
                WR_DONE, RD_DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    l2_req    <= 1'b0;
                    l2_we     <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    line_beat_shifter u_line (
        .clk        (clk),
        .rst        (rst),
        .load       (load_victim),
        .load_line  (wdata_L1_L2),
        .beat       (beat_reg),
        .merge      (merge_beat),
        .merge_data (l2_rdata),
        .wr_beat    (l2_wdata),
        .rd_line    (rdata_L2_L1)
    );

endmodule

// File: tb/tb_l1_d_l2_bridge.sv
// Directed bench for the L1<->L2 line bridge: refill, writeback with ack
// gaps, write-over-read priority, mid-transfer reset, back-to-back, stray acks.
module tb_l1_d_l2_bridge;

    logic         clk = 1'b0;
    logic         rst;
    logic         read_L1_L2;
    logic         write_L1_L2;
    logic [31:0]  addr_L1_L2;
    logic [511:0] wdata_L1_L2;
    logic         ready_L2_L1;
    logic         write_L1_L2_done;
    logic [511:0] rdata_L2_L1;
    logic         busy;
    logic         l2_req;
    logic         l2_we;
    logic [31:0]  l2_addr;
    logic [63:0]  l2_wdata;
    logic         l2_ack;
    logic [63:0]  l2_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l1_d_l2_bridge dut (
        .clk              (clk),
        .rst              (rst),
        .read_L1_L2       (read_L1_L2),
        .write_L1_L2      (write_L1_L2),
        .addr_L1_L2       (addr_L1_L2),
        .wdata_L1_L2      (wdata_L1_L2),
        .ready_L2_L1      (ready_L2_L1),
        .write_L1_L2_done (write_L1_L2_done),
        .rdata_L2_L1      (rdata_L2_L1),
        .busy             (busy),
        .l2_req           (l2_req),
        .l2_we            (l2_we),
        .l2_addr          (l2_addr),
        .l2_wdata         (l2_wdata),
        .l2_ack           (l2_ack),
        .l2_rdata         (l2_rdata)
    );

    // L2 read data: multiples of 0x1111.. by beat index, or a tag plus the beat address.
    function automatic logic [63:0] rd_beat(input logic [31:0] a, input bit mul);
        logic [63:0] k;
        k = {61'd0, a[5:3]};
        if (mul) return 64'h1111_1111_1111_1111 * k;
        return {32'h600D_F00D, a};
    endfunction

    function automatic logic [511:0] rd_line(input logic [31:0] base, input bit mul);
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = rd_beat(base + 32'(8*k), mul);
        return l;
    endfunction

    function automatic logic [63:0] wb_beat(input int k);
        return {16'hBEEF, 16'(k), 32'hC0FF_EE00 + 32'(k)};
    endfunction

    function automatic logic [511:0] wb_line();
        logic [511:0] l;
        for (int k = 0; k < 8; k++) l[64*k +: 64] = wb_beat(k);
        return l;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; read_L1_L2 = 1'b0; write_L1_L2 = 1'b0; addr_L1_L2 = '0;
        wdata_L1_L2 = '0; l2_ack = 1'b0; l2_rdata = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (l2_req !== 1'b0 || l2_we !== 1'b0 || ready_L2_L1 !== 1'b0 || write_L1_L2_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: req=%b we=%b ready=%b done=%b busy=%b, want all 0",
                     l2_req, l2_we, ready_L2_L1, write_L1_L2_done, busy);
        end
        n_checks++;
        if (l2_addr !== 32'd0 || l2_wdata !== 64'd0 || rdata_L2_L1 !== 512'd0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h wdata=%h rdata=%h, want all 0", l2_addr, l2_wdata, rdata_L2_L1);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_refill();
        logic [31:0]  base;
        logic [511:0] exp_line;
        logic [31:0]  exp_a;
        base = 32'h1234_5640;
        exp_line = rd_line(base, 1'b1);
        read_L1_L2 = 1'b1; addr_L1_L2 = 32'h1234_5678; l2_ack = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            tick();
            if (cyc <= 8) begin
                exp_a = base + 32'(8*(cyc-1));
                n_checks++;
                if (l2_req !== 1'b1 || l2_we !== 1'b0 || l2_addr !== exp_a || ready_L2_L1 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL refill_beat%0d: req=%b we=%b addr=%h ready=%b, want req=1 we=0 addr=%h ready=0",
                             cyc-1, l2_req, l2_we, l2_addr, ready_L2_L1, exp_a);
                end
                l2_rdata = rd_beat(exp_a, 1'b1);
            end else if (cyc == 9) begin
                n_checks++;
                if (ready_L2_L1 !== 1'b1 || rdata_L2_L1 !== exp_line) begin
                    n_fail++;
                    $display("FAIL refill_done: ready=%b rdata=%h, want ready=1 rdata=%h", ready_L2_L1, rdata_L2_L1, exp_line);
                end
                read_L1_L2 = 1'b0; l2_ack = 1'b0;
            end else begin
                n_checks++;
                if (ready_L2_L1 !== 1'b0 || busy !== 1'b0 || rdata_L2_L1 !== exp_line) begin
                    n_fail++;
                    $display("FAIL refill_after: ready=%b busy=%b rdata=%h, want ready=0 busy=0 rdata=%h",
                             ready_L2_L1, busy, rdata_L2_L1, exp_line);
                end
            end
        end
        $display("refill: addr 12345678 line transferred");
    endtask

    task automatic test_writeback_gaps();
        int gaps [8] = '{2, 0, 3, 1, 0, 3, 2, 1};
        int k = 0;
        int w = 0;
        int pulses = 0;
        bit done = 1'b0;
        logic [31:0] exp_a;
        write_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_0FC0; wdata_L1_L2 = wb_line(); l2_ack = 1'b0;
        tick();
        addr_L1_L2 = 32'hFFFF_FFC0; wdata_L1_L2 = ~wb_line();
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            if (write_L1_L2_done === 1'b1) begin
                pulses++; done = 1'b1; write_L1_L2 = 1'b0; l2_ack = 1'b0;
                n_checks++;
                if (k != 8) begin
                    n_fail++;
                    $display("FAIL wb_early_done: beats acked=%0d, want 8", k);
                end
            end else if (k > 7) begin
                n_checks++; n_fail++; done = 1'b1;
                $display("FAIL wb_no_done: done=%b after 8 acks, want 1", write_L1_L2_done);
            end else begin
                exp_a = 32'h0000_0FC0 + 32'(8*k);
                n_checks++;
                if (l2_req !== 1'b1 || l2_we !== 1'b1 || l2_addr !== exp_a || l2_wdata !== wb_beat(k)) begin
                    n_fail++;
                    $display("FAIL wb_beat%0d: req=%b we=%b addr=%h wdata=%h, want req=1 we=1 addr=%h wdata=%h",
                             k, l2_req, l2_we, l2_addr, l2_wdata, exp_a, wb_beat(k));
                end
                if (w < gaps[k]) begin
                    l2_ack = 1'b0; w++;
                end else begin
                    l2_ack = 1'b1; k++; w = 0;
                end
            end
            tick();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL wb_timeout: done=%b, want pulse within 80 cycles", write_L1_L2_done);
        end
        if (write_L1_L2_done === 1'b1) pulses++;
        n_checks++;
        if (pulses != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wb_pulse: pulses=%0d busy=%b, want 1 and 0", pulses, busy);
        end
        $display("writeback: addr 00000FC0 with ack gaps, pulses=%0d", pulses);
    endtask

    task automatic test_simultaneous();
        bit          e_req, e_we, e_done, e_rdy, e_busy;
        logic [31:0] e_a;
        read_L1_L2 = 1'b1; write_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_2000;
        wdata_L1_L2 = wb_line(); l2_ack = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            e_req = (c <= 8) || (c >= 11 && c <= 18);
            e_we = (c <= 8);
            e_done = (c == 9);
            e_rdy = (c == 19);
            e_busy = (c != 10 && c != 20);
            e_a = (c <= 8) ? 32'h0000_2000 + 32'(8*(c-1)) : 32'h0000_5000 + 32'(8*(c-11));
            n_checks++;
            if (l2_req !== e_req || l2_we !== e_we || write_L1_L2_done !== e_done ||
                ready_L2_L1 !== e_rdy || busy !== e_busy || (e_req && l2_addr !== e_a)) begin
                n_fail++;
                $display("FAIL simul_c%0d: req=%b we=%b done=%b ready=%b busy=%b addr=%h, want %b %b %b %b %b %h",
                         c, l2_req, l2_we, write_L1_L2_done, ready_L2_L1, busy, l2_addr,
                         e_req, e_we, e_done, e_rdy, e_busy, e_a);
            end
            if (c <= 8) begin
                n_checks++;
                if (l2_wdata !== wb_beat(c-1)) begin
                    n_fail++;
                    $display("FAIL simul_wdata%0d: wdata=%h, want %h", c-1, l2_wdata, wb_beat(c-1));
                end
            end
            if (c == 9) begin
                write_L1_L2 = 1'b0; addr_L1_L2 = 32'h0000_5000;
            end
            if (c >= 11 && c <= 18) l2_rdata = rd_beat(e_a, 1'b0);
            if (c == 19) begin
                read_L1_L2 = 1'b0; l2_ack = 1'b0;
                n_checks++;
                if (rdata_L2_L1 !== rd_line(32'h0000_5000, 1'b0)) begin
                    n_fail++;
                    $display("FAIL simul_rdata: rdata=%h, want %h", rdata_L2_L1, rd_line(32'h0000_5000, 1'b0));
                end
            end
        end
        $display("simultaneous: writeback 00002000 then refill 00005000");
    endtask

    task automatic test_reset_mid_read();
        int lat = 0;
        read_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_3000; l2_ack = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 4) l2_rdata = rd_beat(32'h0000_3000 + 32'(8*(c-1)), 1'b0);
            if (c == 5) begin
                rst = 1'b1; read_L1_L2 = 1'b0; l2_ack = 1'b0;
            end
            n_checks++;
            if (ready_L2_L1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rstmid_ready_c%0d: ready=%b, want 0", c, ready_L2_L1);
            end
        end
        n_checks++;
        if (l2_req !== 1'b0 || l2_we !== 1'b0 || busy !== 1'b0 || write_L1_L2_done !== 1'b0 ||
            l2_addr !== 32'd0 || l2_wdata !== 64'd0 || rdata_L2_L1 !== 512'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: req=%b we=%b busy=%b done=%b addr=%h wdata=%h rdata=%h, want all 0",
                     l2_req, l2_we, busy, write_L1_L2_done, l2_addr, l2_wdata, rdata_L2_L1);
        end
        rst = 1'b0;
        tick();
        read_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_3040; l2_ack = 1'b1;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            tick();
            if (ready_L2_L1 === 1'b1) lat = c;
            else l2_rdata = rd_beat(32'h0000_3040 + 32'(8*(c-1)), 1'b0);
        end
        read_L1_L2 = 1'b0; l2_ack = 1'b0;
        n_checks++;
        if (lat != 9 || rdata_L2_L1 !== rd_line(32'h0000_3040, 1'b0)) begin
            n_fail++;
            $display("FAIL rstmid_fresh_read: latency=%0d rdata=%h, want 9 and %h",
                     lat, rdata_L2_L1, rd_line(32'h0000_3040, 1'b0));
        end
        tick();
        $display("reset_mid_read: fresh refill latency=%0d", lat);
    endtask

    task automatic test_back_to_back();
        logic [511:0] line1, line2, mix;
        bit e_busy, e_rdy;
        line1 = rd_line(32'h0000_0040, 1'b0);
        line2 = rd_line(32'h0000_0080, 1'b0);
        mix = line1;
        mix[63:0] = rd_beat(32'h0000_0080, 1'b0);
        read_L1_L2 = 1'b1; addr_L1_L2 = 32'h0000_0040; l2_ack = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            e_busy = (c != 10);
            e_rdy = (c == 9 || c == 19);
            n_checks++;
            if (busy !== e_busy || ready_L2_L1 !== e_rdy) begin
                n_fail++;
                $display("FAIL b2b_c%0d: busy=%b ready=%b, want busy=%b ready=%b", c, busy, ready_L2_L1, e_busy, e_rdy);
            end
            if (c <= 8) l2_rdata = rd_beat(32'h0000_0040 + 32'(8*(c-1)), 1'b0);
            if (c >= 11 && c <= 18) l2_rdata = rd_beat(32'h0000_0080 + 32'(8*(c-11)), 1'b0);
            if (c == 9) addr_L1_L2 = 32'h0000_0080;
            if (c == 11) begin
                n_checks++;
                if (l2_addr !== 32'h0000_0080) begin
                    n_fail++;
                    $display("FAIL b2b_addr2: addr=%h, want 00000080", l2_addr);
                end
            end
            if (c == 9 || c == 10 || c == 11 || c == 12 || c == 19) begin
                n_checks++;
                if (rdata_L2_L1 !== (c == 19 ? line2 : (c == 12 ? mix : line1))) begin
                    n_fail++;
                    $display("FAIL b2b_rdata_c%0d: rdata=%h, want %h", c, rdata_L2_L1,
                             (c == 19 ? line2 : (c == 12 ? mix : line1)));
                end
            end
        end
        read_L1_L2 = 1'b0; l2_ack = 1'b0;
        tick();
        $display("back_to_back: refills 00000040 then 00000080");
    endtask

    task automatic test_stray_ack();
        bit pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 6; c++) begin
            l2_ack = pat[c];
            tick();
            n_checks++;
            if (busy !== 1'b0 || l2_req !== 1'b0 || ready_L2_L1 !== 1'b0 || write_L1_L2_done !== 1'b0 ||
                rdata_L2_L1 !== rd_line(32'h0000_0080, 1'b0)) begin
                n_fail++;
                $display("FAIL stray_ack_c%0d: busy=%b req=%b ready=%b done=%b rdata=%h, want 0 0 0 0 %h",
                         c, busy, l2_req, ready_L2_L1, write_L1_L2_done, rdata_L2_L1, rd_line(32'h0000_0080, 1'b0));
            end
        end
        l2_ack = 1'b0;
        $display("stray_ack: 6 idle cycles with ack toggling");
    endtask

    initial begin
        test_reset();
        test_refill();
        test_writeback_gaps();
        test_simultaneous();
        test_reset_mid_read();
        test_back_to_back();
        test_stray_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/l1_d_l2_bridge.md
# l1_d_l2_bridge

Line-transfer engine directly downstream of the L1 data-cache controller. Accepts whole-line refill (`read_L1_L2`) and writeback (`write_L1_L2`) requests and moves each 512-bit line to or from the L2 port as eight 64-bit beats. Returns completion to the L1 controller as single-cycle pulses: `ready_L2_L1` for a refill, `write_L1_L2_done` for a writeback.

## Interface
- `ADDR_W`, 32, byte-address width.
- `LINE_W`, 512, cache-line width; 64-byte line, index at addr[11:6].
- `BEAT_W`, 64, L2 beat width; BEATS = LINE_W/BEAT_W = 8.
- `clk`  in  1  clock; everything on the rising edge.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `read_L1_L2`  in  1  refill request, level; held until `ready_L2_L1`.
- `write_L1_L2`  in  1  writeback request, level; held until `write_L1_L2_done`.
- `addr_L1_L2`  in  ADDR_W  line address; bits [5:0] ignored.
- `wdata_L1_L2`  in  LINE_W  victim line; sampled only at acceptance.
- `ready_L2_L1`  out  1  one-cycle pulse: refill line valid on `rdata_L2_L1`.
- `write_L1_L2_done`  out  1  one-cycle pulse: writeback complete.
- `rdata_L2_L1`  out  LINE_W  assembled refill line.
- `busy`  out  1  high in any state other than IDLE.
- `l2_req`  out  1  beat request; held until `l2_ack`.
- `l2_we`  out  1  1 = write beat, 0 = read beat.
- `l2_addr`  out  ADDR_W  beat byte address = {line[31:6], beat[2:0], 3'b000}.
- `l2_wdata`  out  BEAT_W  write beat k = line[64k+63:64k].
- `l2_ack`  in  1  beat accepted (write) or data valid on `l2_rdata` (read).
- `l2_rdata`  in  BEAT_W  read beat data; valid only with `l2_ack`.

## Operation
- States: IDLE, WR_BEAT, WR_DONE, RD_BEAT, RD_DONE.
- IDLE: if `write_L1_L2`, latch the address and `wdata_L1_L2`, clear the beat counter, go to WR_BEAT. Else if `read_L1_L2`, latch the address, clear the counter, go to RD_BEAT.
- Both requests high in IDLE: writeback wins. This is eviction order; the read is accepted after WR_DONE.
- WR_BEAT: `l2_req`=1, `l2_we`=1. On `l2_ack`: if beat==7, go to WR_DONE; else beat+1.
- RD_BEAT: `l2_req`=1, `l2_we`=0. On `l2_ack`, write `l2_rdata` into line slot [beat]. If beat==7, go to RD_DONE; else beat+1.
- WR_DONE and RD_DONE: assert the matching pulse for exactly one cycle, then go to IDLE. Requests are ignored in DONE states.
- The beat counter is 3 bits and wraps 7 to 0 only on exit. `l2_addr` is always line-aligned plus beat*8.
- `rdata_L2_L1` is stable from the RD_DONE cycle until the first `l2_ack` of the next read. Writebacks never modify it.
- Inputs `addr_L1_L2` and `wdata_L1_L2` may change freely after acceptance; only the latched copies are used.
- `l2_ack` with `l2_req`=0: ignored.

## Timing
- Reset values: state IDLE; `l2_req`, `l2_we`, `ready_L2_L1`, `write_L1_L2_done`, `busy` = 0; `l2_addr`, `l2_wdata`, `rdata_L2_L1` = 0; beat = 0.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.
- Acceptance in IDLE at cycle N: `l2_req` is high from N+1. With `l2_ack` tied high, beats complete at N+1..N+8 and the done pulse is at N+9.
- Each ack wait stretches the latency by one cycle. `l2_addr`, `l2_we` and `l2_wdata` stay stable while `l2_req`=1 and `l2_ack`=0.
- Earliest next acceptance is N+10 (the IDLE cycle after DONE). The requester deasserts on the edge that samples the pulse.
- `rst` mid-transfer: on the next edge, return to IDLE and drop `l2_req`. No done pulse, and the partially filled line is discarded.

## Structure
- Shared package `l1_cache_pkg`:
  - ADDR_W, LINE_W, BEAT_W and BEATS.
  - Offset/index/tag bit positions (tag [31:12], index [11:6]).
  - The bridge state enum.
- One natural sub-module, `line_beat_shifter`: it holds the 512-bit line register, selects the write beat by index, and merges read beats by index. The FSM and counter stay in `l1_d_l2_bridge`.

## Test plan
- Refill, ack tied 1: read at addr 0x1234_5678, L2 returns beat k = 0x1111_1111_1111_1111*k → `l2_addr` = 0x1234_5640..0x1234_5678 step 8; `ready_L2_L1` pulses 9 cycles after acceptance; `rdata_L2_L1`[64k+:64] = beat k.
- Writeback with random ack gaps of 0–3 cycles: line = {8 distinct beats} at 0x0000_0FC0 → eight writes in order 0x0FC0..0x0FF8 with matching `l2_wdata`; addr/data stable while waiting; `write_L1_L2_done` pulses once.
- Simultaneous read+write in IDLE → writeback beats first, then `write_L1_L2_done`; read accepted the cycle after WR_DONE; `ready_L2_L1` follows.
- `rst` asserted after beat 3 of a read → `l2_req`=0 next cycle; no `ready_L2_L1`; all outputs at reset values; a fresh read then completes normally.
- Back-to-back reads to 0x0000_0040 then 0x0000_0080 → `rdata_L2_L1` holds line 1 until the first ack of read 2; `busy` drops for exactly one cycle between them.
- Stray `l2_ack` pulses in IDLE → no state change and no pulses.
